// File: rtl/memory_bank_if.sv
// Bus bundle for memory_bank_m: write port, read port and clear-engine handshake.
interface memory_bank_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
);
  logic                  wr_en;
  logic [AWIDTH-1:0]     wr_addr;
  logic [DWIDTH-1:0]     wr_data;
  logic [DWIDTH/8-1:0]   wr_be;
  logic                  rd_en;
  logic [AWIDTH-1:0]     rd_addr;
  logic [DWIDTH-1:0]     rd_data;
  logic                  rd_valid;
  logic                  clr_req;
  logic                  busy;
  logic                  clr_done;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid, busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
    output rd_data, rd_valid, busy, clr_done
  );
endinterface

// File: rtl/memory_bank_m.sv
// Simple-dual-port RAM with byte enables, pipelined read, collision mode select
// and a whole-array clear engine.
//
// state    | meaning
// ST_IDLE  | normal operation, reads and writes accepted
// ST_CLEAR | zeroing one word per cycle, accesses ignored
module memory_bank_m #(
  parameter int DWIDTH     = 8,
  parameter int AWIDTH     = 5,
  parameter int RD_LATENCY = 1,
  parameter int WR_FIRST   = 0
) (
  input logic          clk,
  input logic          rst,
  memory_bank_if.slave bus
);
  localparam int NBYTES = DWIDTH / 8;
  localparam int DEPTH  = 1 << AWIDTH;

  if ((DWIDTH % 8) != 0 || DWIDTH < 8) begin : g_bad_dwidth
    $fatal(1, "memory_bank_m: DWIDTH must be a positive multiple of 8");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
    $fatal(1, "memory_bank_m: RD_LATENCY must be in 1..3");
  end

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                clr_done_q, clr_done_d;

  logic [DWIDTH-1:0]   mem_q [DEPTH];
  logic [RD_LATENCY-1:0] vld_q;
  logic [DWIDTH-1:0]   data_q [RD_LATENCY];

  logic                accept;
  logic                wr_fire;
  logic                rd_fire;
  logic [DWIDTH-1:0]   wr_merged;
  logic [DWIDTH-1:0]   rd_word;

  // A clear request on the same edge wins over any access.
  assign accept  = (state_q == ST_IDLE) && !bus.clr_req;
  assign wr_fire = accept && bus.wr_en;
  assign rd_fire = accept && bus.rd_en;

  always_comb begin
    wr_merged = mem_q[bus.wr_addr];
    for (int b = 0; b < NBYTES; b++) begin
      if (bus.wr_be[b]) wr_merged[8*b +: 8] = bus.wr_data[8*b +: 8];
    end
  end

  always_comb begin
    rd_word = mem_q[bus.rd_addr];
    if (WR_FIRST != 0 && wr_fire && (bus.rd_addr == bus.wr_addr)) rd_word = wr_merged;
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Storage is deliberately not reset; rst only blocks updates so an abort keeps partial contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) mem_q[clr_cnt_q] <= '0;
      else if (wr_fire)        mem_q[bus.wr_addr] <= wr_merged;
    end
  end

  // Each stage loads data only with a valid, so the output stage holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_fire;
      if (rd_fire) data_q[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign bus.rd_data  = data_q[RD_LATENCY-1];
  assign bus.rd_valid = vld_q[RD_LATENCY-1];
  assign bus.busy     = (state_q == ST_CLEAR);
  assign bus.clr_done = clr_done_q;

  a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({bus.wr_en, bus.rd_en, bus.clr_req}))
    else $error("memory_bank_m: X on wr_en/rd_en/clr_req");

endmodule

// File: doc/memory_bank_m.md
Name: memory_bank_m

Overview:
- Parametrised successor to the single-port memory model: a simple-dual-port synchronous RAM (one write port, one read port) on a shared clock.
- Adds over the previous generation:
  - per-byte write enables
  - configurable read pipeline latency with a valid strobe
  - selectable read/write collision mode
  - a hardware clear engine that zeroes the whole array
- Sits behind the memory interface as the storage model used by the memory test program and larger testbench tops.

Parameters:
- DWIDTH, 8: data width in bits; must be a multiple of 8 (elaboration-time fatal otherwise).
- AWIDTH, 5: address width; depth = 2**AWIDTH words.
- RD_LATENCY, 1: read latency in cycles; legal range 1..3 (elaboration-time fatal otherwise).
- WR_FIRST, 0: collision mode. 0 = read returns old data; 1 = read returns newly written data.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request.
- wr_addr  input  AWIDTH  write address.
- wr_data  input  DWIDTH  write data.
- wr_be  input  DWIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  input  1  read request.
- rd_addr  input  AWIDTH  read address.
- rd_data  output  DWIDTH  read data, registered.
- rd_valid  output  1  rd_data is valid this cycle.
- clr_req  input  1  start clear of the entire array.
- busy  output  1  clear in progress; accesses are ignored.
- clr_done  output  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - rd_data=0, rd_valid=0, busy=0, clr_done=0, read pipeline flushed, FSM=IDLE, clear counter=0.
  - Array contents are NOT reset.
- Write: in IDLE, if wr_en is sampled at edge k, bytes with wr_be[i]=1 update at edge k; other bytes are unchanged. wr_be=0 means no change.
- Read: in IDLE, if rd_en is sampled at edge k, rd_data/rd_valid reflect the addressed word after edge k+RD_LATENCY-1.
  - So at RD_LATENCY=1 they are visible in the cycle following edge k.
  - rd_valid is high for exactly one cycle per accepted read.
  - Back-to-back reads every cycle are supported (full throughput).
  - When rd_valid=0, rd_data holds its last value.
- Collision (rd_en and wr_en both set, rd_addr==wr_addr, same edge):
  - WR_FIRST=0: returns the pre-write word.
  - WR_FIRST=1: returns the merged word (enabled bytes new, others old).
  - A read issued at a later edge always sees the write.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR: clr_req=1 sampled. busy rises after that edge, and the counter starts at 0.
  - In CLEAR: one word is zeroed per cycle at address = counter, and the counter increments.
  - After word 2**AWIDTH-1 is written (2**AWIDTH cycles total): FSM -> IDLE, busy falls, and clr_done pulses for one cycle on the same edge.
- In CLEAR, and on the edge clr_req is accepted:
  - wr_en/rd_en are ignored: no array write and no rd_valid.
  - Reads already in the pipeline still complete and return their data.
  - Clear has priority over simultaneous accesses.
- clr_req while busy is ignored (no restart).
- Reset mid-clear: the clear aborts immediately, FSM=IDLE, and partially cleared contents remain. clr_done does not pulse.
- Addresses wrap naturally within AWIDTH; there are no out-of-range addresses.
- X on wr_en/rd_en/clr_req outside reset: simulation assertion error.

Test Plan:
- DWIDTH=16, RD_LATENCY=2. Write 0xBEEF to addr 3, be=2'b11, then read addr 3 -> rd_valid high exactly 2 cycles after the read edge, rd_data=0xBEEF.
- Write 0x1234 to addr 7 with be=2'b01, following 0xFFFF in that word -> read returns 0xFF34.
- Same-cycle write 0xAAAA / read of addr 5, where the old word is 0x5555 -> WR_FIRST=0 returns 0x5555; WR_FIRST=1 returns 0xAAAA.
- AWIDTH=5, fill all words, pulse clr_req with a simultaneous wr_en:
  - busy is high for 32 cycles, clr_done pulses once, and the write is dropped.
  - All 32 reads afterwards return 0.
- Assert rst at clear cycle 10 -> busy=0 and rd_valid=0 immediately.
  - Addrs 0..9 read 0, addrs 10..31 keep their old values, and no clr_done pulse occurs.
- 32 back-to-back reads with RD_LATENCY=3 -> 32 consecutive rd_valid cycles, data in address order.
